sbox_sub_pipe: RTL
==================

SBOX_SUB_PIPE -- requirements
Module: sbox_sub_pipe

Interface
REQ-001 Parameter LANES, default 16, SHALL set the number of byte lanes substituted per beat (1..16).
REQ-002 Parameter STAGES, default 2, SHALL set the pipeline depth in register stages (1..3).
REQ-003 Parameter TAG_W, default 4, SHALL set the width of a sideband tag carried alongside each beat.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 in_valid  input  1  SHALL mark a valid input beat.
REQ-007 in_ready  output  1  SHALL indicate the block accepts a beat this cycle.
REQ-008 in_data  input  8*LANES  SHALL carry the bytes to substitute; lane k occupies bits [8k+7:8k].
REQ-009 in_inv  input  1  SHALL select the mapping per beat: 0 = forward S-box, 1 = inverse S-box.
REQ-010 in_tag  input  TAG_W  SHALL carry an opaque tag, returned unmodified with the beat.
REQ-011 out_valid  output  1  SHALL mark a valid output beat.
REQ-012 out_ready  input  1  SHALL indicate the consumer accepts a beat this cycle.
REQ-013 out_data  output  8*LANES  SHALL carry the substituted bytes in the same lane order as the input.
REQ-014 out_tag  output  TAG_W  SHALL carry the tag of the beat on out_data.
REQ-015 beat_cnt  output  16  SHALL count the output beats accepted since reset.

Function
REQ-016 A beat SHALL transfer on the input when in_valid and in_ready are both 1, and on the output when out_valid and out_ready are both 1.
REQ-017 Each output lane SHALL equal S(in byte) when in_inv = 0, and InvS(in byte) when in_inv = 1, using the FIPS-197 tables.
REQ-018 The in_inv value SHALL be sampled with its beat, so beats with different modes may be interleaved back to back.
REQ-019 Latency SHALL be exactly STAGES cycles from input transfer to out_valid when out_ready is held at 1.
REQ-020 Throughput SHALL be one beat per cycle when out_ready is held at 1.
REQ-021 Each stage SHALL hold a valid bit; a stage SHALL load when it is empty or when its contents advance in the same cycle.
REQ-022 in_ready SHALL equal NOT(stage-1 valid) OR (stage 1 advancing this cycle); no beat is lost or duplicated under backpressure.
REQ-023 Once asserted, out_valid with out_data and out_tag SHALL stay stable until the output transfer completes.
REQ-024 When the pipe is full and out_ready = 0, in_ready SHALL be 0.
REQ-025 When the pipe is full and out_ready = 1, a simultaneous input and output transfer SHALL both occur in that cycle.
REQ-026 The table lookup SHALL be registered in stage 1; later stages SHALL be pure transport registers.
REQ-027 beat_cnt SHALL increment by 1 on each output transfer and wrap from 0xFFFF to 0x0000.
REQ-028 Beats SHALL leave the block in the same order they entered.

Reset
REQ-029 While rst = 1, all stage valid bits, out_valid, out_data, out_tag and beat_cnt SHALL be cleared to 0.
REQ-030 While rst = 1, in_ready SHALL be 0.
REQ-031 Asserting rst mid-operation SHALL discard every in-flight beat, with no output after reset is released.
REQ-032 in_ready SHALL become 1 on the first cycle after rst is deasserted.

Structure
REQ-033 Package aes_pkg SHALL hold the byte type and the 256-entry SBOX and INV_SBOX constant tables, shared with the encrypt and decrypt datapaths.
REQ-034 A combinational sub-module sbox_lane (8-bit input, inv select, 8-bit output) SHALL be instantiated LANES times.
REQ-035 The stage-control logic SHALL be written once and replicated by generate over STAGES.

Verification
REQ-036 Forward, LANES=16, STAGES=2, out_ready=1: lane bytes 0x00 and 0x53, tag 0x5 -> after 2 cycles lanes 0x63 and 0xED, tag 0x5.
REQ-037 Inverse: lane bytes 0x00, 0x63, 0xED, 0x0C -> 0x52, 0x00, 0x53, 0x81.
REQ-038 Mode interleave: back-to-back beats inv=0 then inv=1, both 0x01 -> outputs 0x7C then 0x09 on consecutive cycles.
REQ-039 Backpressure: stream 8 tagged beats with out_ready toggling pseudo-randomly -> all 8 emerge in order with correct data and tags, and beat_cnt = 8.
REQ-040 Reset mid-stream: assert rst for 1 cycle with 2 beats in flight -> outputs cleared, no stale beat appears, and in_ready = 1 the next cycle.
REQ-041 Exhaustive: all 256 bytes in both modes -> each inverse output of a forward output returns the original byte; 65536 transfers wrap beat_cnt to 0x0000.

Source files
------------

// File: rtl/aes_pkg.sv
// Byte type and FIPS-197 substitution tables, shared by the encrypt and decrypt datapaths.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_lane.sv
// One byte lane of substitution: forward or inverse table selected per beat.
module sbox_lane
  import aes_pkg::*;
(
  input  byte_t i_byte,
  input  logic  i_inv,
  output byte_t o_byte
);

  always_comb begin
    o_byte = i_inv ? INV_SBOX[i_byte] : SBOX[i_byte];
  end

endmodule

// File: rtl/sbox_sub_pipe.sv
// LANES-wide S-box substitution with a STAGES-deep valid/ready pipeline carrying a tag.
module sbox_sub_pipe
  import aes_pkg::*;
#(
  parameter int unsigned LANES  = 16,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_inv,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic [15:0]          beat_cnt
);

  localparam int unsigned DW = 8 * LANES;

  logic [DW-1:0]     w_sub;
  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_load;
  logic [DW-1:0]     w_data [STAGES];
  logic [TAG_W-1:0]  w_tag  [STAGES];
  logic [15:0]       r_beat_cnt;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane u_lane (
      .i_byte (in_data[8*l +: 8]),
      .i_inv  (in_inv),
      .o_byte (w_sub[8*l +: 8])
    );
  end

  // A stage may load if the consumer takes a beat, or a bubble exists at or after it.
  for (genvar g = 0; g < STAGES; g++) begin : g_load
    assign w_load[g] = out_ready || !(&w_valid[STAGES-1:g]);
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic             w_src_valid;
    logic [DW-1:0]    w_src_data;
    logic [TAG_W-1:0] w_src_tag;
    logic             r_valid;
    logic [DW-1:0]    r_data;
    logic [TAG_W-1:0] r_tag;

    if (g == 0) begin : g_head
      assign w_src_valid = in_valid;
      assign w_src_data  = w_sub;
      assign w_src_tag   = in_tag;
    end else begin : g_body
      assign w_src_valid = w_valid[g-1];
      assign w_src_data  = w_data[g-1];
      assign w_src_tag   = w_tag[g-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_tag   <= '0;
      end else if (w_load[g]) begin
        r_valid <= w_src_valid;
        r_data  <= w_src_data;
        r_tag   <= w_src_tag;
      end
    end

    assign w_valid[g] = r_valid;
    assign w_data[g]  = r_data;
    assign w_tag[g]   = r_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= 16'h0000;
    end else if (out_valid && out_ready) begin
      r_beat_cnt <= r_beat_cnt + 16'd1;
    end
  end

  assign in_ready  = !rst && w_load[0];
  assign out_valid = w_valid[STAGES-1];
  assign out_data  = w_data[STAGES-1];
  assign out_tag   = w_tag[STAGES-1];
  assign beat_cnt  = r_beat_cnt;

endmodule
